add_acc_serial: RTL and testbench
=================================

ADD_ACC_SERIAL -- requirements
Module: add_acc_serial

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; SHALL be a multiple of DIGIT.
REQ-002 Parameter DIGIT, default 4, bits added per clock cycle; NDIG = WIDTH/DIGIT digit cycles per operation.
REQ-003 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request an operation; sampled only in IDLE.
REQ-006 acc_mode  input  1  sampled with start; 1 = second operand is out[WIDTH-1:0] (accumulate), 0 = second operand is in2.
REQ-007 clr  input  1  clear result register; honoured only in IDLE.
REQ-008 in1  input  WIDTH  first operand, sampled with start.
REQ-009 in2  input  WIDTH  second operand, sampled with start.
REQ-010 busy  output  1  high while in RUN.
REQ-011 done  output  1  single-cycle pulse, result valid.
REQ-012 out  output  WIDTH+1  registered result; out[WIDTH] = carry-out.

Function
REQ-013 FSM states: IDLE, RUN, DONE; reset state IDLE.
REQ-014 IDLE with start=1 and clr=0: latch in1, second operand per acc_mode, carry=0, digit index=0; go to RUN.
REQ-015 RUN: each cycle add one DIGIT-bit slice, LSB slice first, with the stored carry; store sum slice in a working register and update carry; increment index.
REQ-016 RUN SHALL last exactly NDIG cycles; after slice NDIG-1, go to DONE and load out = {final carry, working sum}.
REQ-017 DONE: done=1 for exactly one cycle; next state IDLE unconditionally.
REQ-018 Latency: start sampled at edge k -> busy high for cycles after edges k..k+NDIG-1 -> done high in cycle after edge k+NDIG.
REQ-019 out SHALL change only on entry to DONE, on clr, or on reset; it holds its value otherwise, including during RUN.
REQ-020 Arithmetic unsigned; result = in1 + operand2, exact in WIDTH+1 bits; accumulate uses out[WIDTH-1:0] only, so the accumulator wraps modulo 2^WIDTH with the carry reported in out[WIDTH].
REQ-021 start in RUN or DONE SHALL be ignored (no queuing); in1/in2/acc_mode changes during RUN SHALL have no effect.
REQ-022 clr in IDLE: out <= 0 next edge; clr and start together in IDLE: clear wins, start ignored, stay IDLE.
REQ-023 clr in RUN or DONE SHALL be ignored.
REQ-024 Back-to-back: start may be re-asserted in the IDLE cycle immediately after done.

Reset
REQ-025 rst_n low SHALL immediately force: state IDLE, busy=0, done=0, out=0, carry=0, index=0, working register=0.
REQ-026 Reset during RUN SHALL abort the operation with no done pulse; first start after release behaves as from power-up.

Structure
REQ-027 State encoding and default WIDTH/DIGIT constants SHALL live in shared package mac_pkg.
REQ-028 One combinational sub-module digit_adder (DIGIT-bit add with carry-in/carry-out), instantiated once, driven by the current slice.
REQ-029 Digit index counter width SHALL be clog2(NDIG), minimum 1.

Verification
REQ-030 WIDTH=16, DIGIT=4: in1=0xFFFF, in2=0x0001, acc_mode=0, start at edge k -> busy for 4 cycles, done in cycle after edge k+4, out=0x10000.
REQ-031 Accumulate: clr; then start acc_mode=1 in1=0x8000 twice -> out=0x08000, then out=0x10000 (low bits wrapped to 0, carry=1).
REQ-032 start re-pulsed during RUN with different operands -> ignored; single done; out reflects first operands only.
REQ-033 clr and start asserted together in IDLE with out=0x01234 -> out=0x00000, no busy, no done.
REQ-034 rst_n asserted at second RUN cycle of 0x1234+0x4321 -> all outputs 0 immediately, no done; new start after release -> out=0x05555 with correct latency.
REQ-035 DIGIT=16 (NDIG=1) and DIGIT=1 (NDIG=16) builds: random operands -> out matches in1+in2, latency NDIG+1 edges.

Source files
------------

// File: rtl/mac_pkg.sv
// Purpose: shared constants for the digit-serial adder/accumulator (FSM encoding, default sizes).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: DEF_WIDTH/DEF_DIGIT defaults, ST_* state codes, idx_width() helper for the digit counter.
package mac_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DIGIT = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Digit index width: clog2 of the digit count, never narrower than one bit
  // so a single-digit build still has a legal counter.
  function automatic int idx_width(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Purpose: combinational DIGIT-bit adder with carry-in and carry-out.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
// Ports: a, b = digit operands; cin = carry in; sum = digit sum; cout = carry out.
module digit_adder
  import mac_pkg::*;
#(
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};

endmodule

// File: rtl/add_acc_serial.sv
// Purpose: digit-serial unsigned adder/accumulator, WIDTH/DIGIT digits per operation, LSB digit first.
// Latency: start at edge k -> busy for NDIG cycles -> done pulse in the cycle after edge k+NDIG.
// Backpressure: none; start is only accepted in IDLE, requests in RUN/DONE are dropped (no queuing).
// Ports: clk/rst_n (async active-low); start, acc_mode, clr, in1, in2 in; busy, done, out[WIDTH:0] out.
module add_acc_serial
  import mac_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT   // WIDTH must be a multiple of DIGIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             acc_mode,
  input  logic             clr,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   out
);

  localparam int              NDIG = WIDTH / DIGIT;
  localparam int              IW   = idx_width(NDIG);
  localparam logic [IW-1:0]   LAST = IW'(NDIG - 1);

  logic [1:0]       state_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_nxt;
  logic             carry_q;
  logic [IW-1:0]    idx_q;

  logic [DIGIT-1:0] sl_a;
  logic [DIGIT-1:0] sl_b;
  logic [DIGIT-1:0] sl_s;
  logic             sl_co;

  // Current digit slice of each latched operand.
  assign sl_a = opa_q[idx_q*DIGIT +: DIGIT];
  assign sl_b = opb_q[idx_q*DIGIT +: DIGIT];

  digit_adder #(
    .DIGIT (DIGIT)
  ) u_digit_adder (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry_q),
    .sum  (sl_s),
    .cout (sl_co)
  );

  // Working sum with this cycle's digit merged in; on the last digit this is
  // the complete low part of the result, so out can load it the same edge.
  always_comb begin
    sum_nxt = sum_q;
    sum_nxt[idx_q*DIGIT +: DIGIT] = sl_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      out     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Clear has priority over start and keeps the FSM in IDLE.
          if (clr) begin
            out <= '0;
          end else if (start) begin
            opa_q   <= in1;
            // Accumulate reuses only the low WIDTH bits; the old carry is dropped.
            opb_q   <= acc_mode ? out[WIDTH-1:0] : in2;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          sum_q   <= sum_nxt;
          carry_q <= sl_co;
          idx_q   <= idx_q + IW'(1);
          if (idx_q == LAST) begin
            out     <= {sl_co, sum_nxt};
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_add_acc_serial.sv
// Purpose: self-checking bench for add_acc_serial; three builds (DIGIT=4, 16, 1) share one stimulus stream.
// Latency: each operation is watched for 18 cycles so the slowest build (NDIG=16) always returns to IDLE.
// Backpressure: the bench only issues start when every build is idle; re-pulses inside RUN must be dropped.
module tb_add_acc_serial;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        acc_mode;
  logic        clr;
  logic [15:0] in1;
  logic [15:0] in2;
  logic [2:0]  busy_v;
  logic [2:0]  done_v;
  logic [16:0] out_v [3];

  int          total = 0;
  int          bad   = 0;
  logic [16:0] model_out;
  int          ndig_of [3] = '{4, 1, 16};

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        acc;
    logic        clrv;
    logic        st;
    logic [16:0] exp;
  } vec_t;

  vec_t tbl [13];

  always #5 clk = ~clk;

  add_acc_serial #(.WIDTH(16), .DIGIT(4)) u_d4 (
    .clk (clk), .rst_n (rst_n), .start (start), .acc_mode (acc_mode), .clr (clr),
    .in1 (in1), .in2 (in2), .busy (busy_v[0]), .done (done_v[0]), .out (out_v[0])
  );

  add_acc_serial #(.WIDTH(16), .DIGIT(16)) u_d16 (
    .clk (clk), .rst_n (rst_n), .start (start), .acc_mode (acc_mode), .clr (clr),
    .in1 (in1), .in2 (in2), .busy (busy_v[1]), .done (done_v[1]), .out (out_v[1])
  );

  add_acc_serial #(.WIDTH(16), .DIGIT(1)) u_d1 (
    .clk (clk), .rst_n (rst_n), .start (start), .acc_mode (acc_mode), .clr (clr),
    .in1 (in1), .in2 (in2), .busy (busy_v[2]), .done (done_v[2]), .out (out_v[2])
  );

  task automatic check(input string nm, input int i, input int c,
                       input logic [16:0] got, input logic [16:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s inst=%0d cyc=%0d got=%h want=%h", nm, i, c, got, want);
    end
  endtask

  task automatic check_all_zero(input string nm, input int c);
    for (int i = 0; i < 3; i++) begin
      check({nm, "_busy"}, i, c, {16'b0, busy_v[i]}, 17'd0);
      check({nm, "_done"}, i, c, {16'b0, done_v[i]}, 17'd0);
      check({nm, "_out"},  i, c, out_v[i], 17'd0);
    end
  endtask

  // One operation: drive the request for one cycle, then watch every build for
  // 18 cycles against the expected busy window, done slot and out value.
  // rp re-pulses start (with clr) while builds are in RUN/DONE; both must be ignored.
  task automatic op(input logic [15:0] a, input logic [15:0] b, input logic acc,
                    input logic clrv, input logic st, input logic rp,
                    input logic [16:0] exp);
    logic act;
    int   n;
    act = st && !clrv;
    @(negedge clk);
    start = st; clr = clrv; in1 = a; in2 = b; acc_mode = acc;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        n = ndig_of[i];
        check("busy", i, c, {16'b0, busy_v[i]}, {16'b0, act && (c <= n)});
        check("done", i, c, {16'b0, done_v[i]}, {16'b0, act && (c == n + 1)});
        check("out",  i, c, out_v[i], (act && (c <= n)) ? model_out : exp);
      end
      if (c == 1) begin
        start = 1'b0; clr = 1'b0;
        in1 = 16'($urandom); in2 = 16'($urandom); acc_mode = 1'($urandom_range(0, 1));
      end
      if (c == 2 && rp) begin
        start = 1'b1; clr = 1'b1; in1 = 16'($urandom); in2 = 16'($urandom);
      end
      if (c == 3) begin
        start = 1'b0; clr = 1'b0;
      end
    end
    model_out = exp;
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic        racc;
    logic        rclr;
    logic        rrp;
    logic [16:0] rexp;

    rst_n = 1'b0; start = 1'b0; acc_mode = 1'b0; clr = 1'b0; in1 = '0; in2 = '0;
    model_out = '0;

    //            a         b         acc   clr   st    exp
    tbl[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 17'h10000};
    tbl[1]  = '{16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1, 17'h05555};
    tbl[2]  = '{16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 17'h00000};
    tbl[3]  = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b1, 17'h1FFFE};
    tbl[4]  = '{16'hAAAA, 16'h5555, 1'b0, 1'b0, 1'b1, 17'h0FFFF};
    tbl[5]  = '{16'h0001, 16'hBEEF, 1'b1, 1'b0, 1'b1, 17'h10000};
    tbl[6]  = '{16'h0005, 16'hBEEF, 1'b1, 1'b0, 1'b1, 17'h00005};
    tbl[7]  = '{16'h7777, 16'h7777, 1'b0, 1'b1, 1'b0, 17'h00000};
    tbl[8]  = '{16'h8000, 16'h1111, 1'b1, 1'b0, 1'b1, 17'h08000};
    tbl[9]  = '{16'h8000, 16'h2222, 1'b1, 1'b0, 1'b1, 17'h10000};
    tbl[10] = '{16'h1234, 16'h0000, 1'b0, 1'b0, 1'b1, 17'h01234};
    tbl[11] = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b1, 17'h00000};
    tbl[12] = '{16'h0F0F, 16'hF0F1, 1'b0, 1'b0, 1'b1, 17'h10000};

    // Reset state.
    #12;
    check_all_zero("reset", 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table.
    for (int t = 0; t < 13; t++) begin
      op(tbl[t].a, tbl[t].b, tbl[t].acc, tbl[t].clrv, tbl[t].st, 1'b0, tbl[t].exp);
    end

    // Start and clr re-pulsed mid-operation with other operands: ignored.
    op(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1, 1'b1, 17'h03333);

    // Reset in the second RUN cycle aborts with everything forced to zero.
    @(negedge clk);
    start = 1'b1; in1 = 16'h1234; in2 = 16'h4321; acc_mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("abort", 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_out = '0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      check_all_zero("post_rst", c);
    end
    op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1, 1'b0, 17'h05555);

    // Random operations against a plain-arithmetic accumulator model.
    for (int r = 0; r < 30; r++) begin
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      racc = ($urandom_range(0, 3) == 0);
      rclr = ($urandom_range(0, 9) == 0);
      rrp  = ($urandom_range(0, 4) == 0);
      if (rclr)
        rexp = 17'd0;
      else if (racc)
        rexp = {1'b0, ra} + {1'b0, model_out[15:0]};
      else
        rexp = {1'b0, ra} + {1'b0, rb};
      op(ra, rb, racc, rclr, 1'b1, rrp, rexp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
